mem_responder: RTL and testbench

Memory-side responder for the core's `mem` package read/write request channels. It accepts `mem_read_req_t` / `mem_write_req_t` from the memory stage and returns `mem_read_rsp_t` / `mem_write_rsp_t` after a fixed, parameterised latency. It is backed by an internal word-organised RAM. It serves as the data-memory model for core bring-up and as the reference responder for the pipeline's memory interface.

---
 rtl/mem_responder.sv | 247 ++++++++++++++++++++++++
 tb/tb_mem_responder.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency memory-side responder backed by a word-organised
// RAM. It serves the memory stage's independent read and write channels.
//
// Package mem carries the request/response types and the mask encodings.
//
// Ports:
//   clk     - sole clock, rising edge
//   rst     - synchronous, active-high reset
//   rd_req  - read request  {addr, mask, en}
//   wr_req  - write request {addr, data, mask, en}
//   rd_rsp  - read response {addr, data, valid, done}, registered
//   wr_rsp  - write response {valid, done}, registered
//
// Each channel accepts one request when idle. It counts out its latency and
// then pulses done for one cycle. A new request can be accepted on the edge
// after done is presented, which gives one request every L+1 cycles.

package mem;
    localparam logic [3:0] mem_req_byte_mask = 4'b0001;
    localparam logic [3:0] mem_req_half_mask = 4'b0011;
    localparam logic [3:0] mem_req_word_mask = 4'b1111;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  mask;
        logic        en;
    } mem_read_req_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic        en;
    } mem_write_req_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        valid;
        logic        done;
    } mem_read_rsp_t;

    typedef struct packed {
        logic valid;
        logic done;
    } mem_write_rsp_t;
endpackage

module mem_responder #(
    parameter int unsigned DEPTH_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  mem::mem_read_req_t  rd_req,
    input  mem::mem_write_req_t wr_req,
    output mem::mem_read_rsp_t  rd_rsp,
    output mem::mem_write_rsp_t wr_rsp
);
    localparam int unsigned AW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned RCW = $clog2(READ_LATENCY + 1);
    localparam int unsigned WCW = $clog2(WRITE_LATENCY + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

    // Legal mask, natural alignment and range check. The range test uses
    // unsigned wrap-around, so an address below the base counts as out of range.
    function automatic logic access_ok(input logic [31:0] addr, input logic [3:0] mask);
        logic aligned;
        case (mask)
            mem::mem_req_byte_mask: aligned = 1'b1;
            mem::mem_req_half_mask: aligned = ~addr[0];
            mem::mem_req_word_mask: aligned = (addr[1:0] == 2'b00);
            default:                aligned = 1'b0;
        endcase
        return aligned && (((addr - BASE_ADDR) >> 2) < 32'(DEPTH_WORDS));
    endfunction

    // ---------------- request decode ----------------
    logic          rd_accept, wr_accept;
    logic          rd_ok_now, wr_ok_now;
    logic [AW-1:0] rd_idx, wr_idx;
    logic [3:0]    wr_lane_en;
    logic [31:0]   wr_data_sh;

    state_t rd_state_q, rd_state_d;
    state_t wr_state_q, wr_state_d;

    // Reset wins over accept, so a request held during reset is not taken.
    assign rd_accept  = !rst && (rd_state_q == ST_IDLE) && rd_req.en;
    assign wr_accept  = !rst && (wr_state_q == ST_IDLE) && wr_req.en;
    assign rd_ok_now  = access_ok(rd_req.addr, rd_req.mask);
    assign wr_ok_now  = access_ok(wr_req.addr, wr_req.mask);
    assign rd_idx     = AW'((rd_req.addr - BASE_ADDR) >> 2);
    assign wr_idx     = AW'((wr_req.addr - BASE_ADDR) >> 2);
    // Right-aligned write data and mask are moved up to their byte lanes.
    assign wr_lane_en = wr_req.mask << wr_req.addr[1:0];
    assign wr_data_sh = wr_req.data << {wr_req.addr[1:0], 3'b000};

    // ---------------- read channel state ----------------
    logic [RCW-1:0]     rd_cnt_q, rd_cnt_d;
    logic [31:0]        rd_addr_q, rd_addr_d;
    logic [3:0]         rd_mask_q, rd_mask_d;
    logic               rd_ok_q, rd_ok_d;
    mem::mem_read_rsp_t rd_rsp_q, rd_rsp_d;
    logic [31:0]        rd_word;
    logic [31:0]        rd_bmask;

    // ---------------- RAM: one byte-wide array per lane ----------------
    // Both ports act at the accept edge. The read captures the old word, so a
    // same-edge write to the same word is not visible to that read.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH_WORDS];
        logic [7:0] rd_byte_q;

        always_ff @(posedge clk) begin
            if (wr_accept && wr_ok_now && wr_lane_en[gi]) begin
                lane_mem[wr_idx] <= wr_data_sh[8*gi +: 8];
            end
            if (rd_accept) begin
                rd_byte_q <= lane_mem[rd_idx];
            end
        end

        assign rd_word[8*gi +: 8]  = rd_byte_q;
        assign rd_bmask[8*gi +: 8] = {8{rd_mask_q[gi]}};
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        rd_addr_d  = rd_addr_q;
        rd_mask_d  = rd_mask_q;
        rd_ok_d    = rd_ok_q;
        rd_rsp_d   = '0;
        case (rd_state_q)
            ST_IDLE: begin
                if (rd_req.en) begin
                    rd_addr_d = rd_req.addr;
                    rd_mask_d = rd_req.mask;
                    rd_ok_d   = rd_ok_now;
                    if (READ_LATENCY == 1) begin
                        rd_state_d = ST_RESP;
                        rd_cnt_d   = '0;
                    end else begin
                        rd_state_d = ST_BUSY;
                        rd_cnt_d   = RCW'(READ_LATENCY - 1);
                    end
                end
            end
            ST_BUSY: begin
                if (rd_cnt_q == RCW'(1)) begin
                    rd_state_d = ST_RESP;
                    rd_cnt_d   = '0;
                end else begin
                    rd_cnt_d   = rd_cnt_q - RCW'(1);
                end
            end
            ST_RESP: begin
                rd_state_d     = ST_IDLE;
                rd_rsp_d.done  = 1'b1;
                rd_rsp_d.valid = rd_ok_q;
                rd_rsp_d.addr  = rd_addr_q;
                // Bring the addressed byte down to bit 0 and keep only the bytes in the mask.
                rd_rsp_d.data  = rd_ok_q ? ((rd_word >> {rd_addr_q[1:0], 3'b000}) & rd_bmask) : '0;
            end
            default: rd_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= ST_IDLE;
            rd_cnt_q   <= '0;
            rd_addr_q  <= '0;
            rd_mask_q  <= '0;
            rd_ok_q    <= 1'b0;
            rd_rsp_q   <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_addr_q  <= rd_addr_d;
            rd_mask_q  <= rd_mask_d;
            rd_ok_q    <= rd_ok_d;
            rd_rsp_q   <= rd_rsp_d;
        end
    end

    // ---------------- write channel state ----------------
    logic [WCW-1:0]      wr_cnt_q, wr_cnt_d;
    logic                wr_ok_q, wr_ok_d;
    mem::mem_write_rsp_t wr_rsp_q, wr_rsp_d;

    always_comb begin
        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        wr_ok_d    = wr_ok_q;
        wr_rsp_d   = '0;
        case (wr_state_q)
            ST_IDLE: begin
                if (wr_req.en) begin
                    wr_ok_d = wr_ok_now;
                    if (WRITE_LATENCY == 1) begin
                        wr_state_d = ST_RESP;
                        wr_cnt_d   = '0;
                    end else begin
                        wr_state_d = ST_BUSY;
                        wr_cnt_d   = WCW'(WRITE_LATENCY - 1);
                    end
                end
            end
            ST_BUSY: begin
                if (wr_cnt_q == WCW'(1)) begin
                    wr_state_d = ST_RESP;
                    wr_cnt_d   = '0;
                end else begin
                    wr_cnt_d   = wr_cnt_q - WCW'(1);
                end
            end
            ST_RESP: begin
                wr_state_d     = ST_IDLE;
                wr_rsp_d.done  = 1'b1;
                wr_rsp_d.valid = wr_ok_q;
            end
            default: wr_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= ST_IDLE;
            wr_cnt_q   <= '0;
            wr_ok_q    <= 1'b0;
            wr_rsp_q   <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_ok_q    <= wr_ok_d;
            wr_rsp_q   <= wr_rsp_d;
        end
    end

    assign rd_rsp = rd_rsp_q;
    assign wr_rsp = wr_rsp_q;
endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder. It runs directed scenarios and then random traffic.
// A byte-addressed reference memory with per-channel accept/done timestamps
// predicts every response cycle. One line is printed per completed transaction.
`timescale 1ns/1ps
module tb_mem_responder;
    import mem::*;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned RL    = 2;
    localparam int unsigned WL    = 1;

    logic           clk = 1'b0;
    logic           rst;
    mem_read_req_t  rd_req;
    mem_write_req_t wr_req;
    mem_read_rsp_t  rd_rsp;
    mem_write_rsp_t wr_rsp;

    always #5 clk = ~clk;

    mem_responder #(
        .DEPTH_WORDS  (DEPTH),
        .BASE_ADDR    (BASE),
        .READ_LATENCY (RL),
        .WRITE_LATENCY(WL)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rd_req(rd_req),
        .wr_req(wr_req),
        .rd_rsp(rd_rsp),
        .wr_rsp(wr_rsp)
    );

    int unsigned err_cnt = 0;
    int unsigned chk_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mdl_mem [DEPTH*4];

    function automatic int unsigned nbytes(input logic [3:0] mask);
        case (mask)
            4'b0001: return 1;
            4'b0011: return 2;
            4'b1111: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit mdl_ok(input logic [31:0] addr, input logic [3:0] mask);
        int unsigned n;
        logic [31:0] rel;
        n   = nbytes(mask);
        rel = addr - BASE;
        if (n == 0) return 1'b0;
        if ((addr % n) != 0) return 1'b0;
        return (rel / 4) < DEPTH;
    endfunction

    int unsigned   edge_n = 0;
    bit            rd_pend = 0, wr_pend = 0;
    int unsigned   rd_done_e = 0, wr_done_e = 0, rd_free_e = 0, wr_free_e = 0;
    int unsigned   rd_acc_cnt = 0, wr_acc_cnt = 0;
    int unsigned   dut_rd_dones = 0, dut_wr_dones = 0;
    int unsigned   last_rd_edge = 0, last_wr_edge = 0;
    logic [31:0]   last_rd_data = '0, last_rd_addr = '0;
    logic          last_rd_valid = 1'b0, last_wr_valid = 1'b0;
    mem_read_rsp_t rd_exp;
    mem_write_rsp_t wr_exp;

    // Monitor: update the model with what the edge accepted, then check outputs.
    initial begin
        int unsigned   n;
        int unsigned   b;
        bit            ok;
        mem_read_rsp_t  er;
        mem_write_rsp_t ew;
        forever begin
            @(posedge clk);
            edge_n++;
            if (rst) begin
                rd_pend = 0; wr_pend = 0; rd_free_e = 0; wr_free_e = 0;
            end else begin
                if (rd_req.en && edge_n >= rd_free_e) begin
                    ok     = mdl_ok(rd_req.addr, rd_req.mask);
                    n      = nbytes(rd_req.mask);
                    rd_exp = '0;
                    rd_exp.done  = 1'b1;
                    rd_exp.valid = ok;
                    rd_exp.addr  = rd_req.addr;
                    if (ok) begin
                        b = rd_req.addr - BASE;
                        for (int i = 0; i < int'(n); i++) rd_exp.data[8*i +: 8] = mdl_mem[b + i];
                    end
                    rd_pend = 1; rd_done_e = edge_n + RL; rd_free_e = rd_done_e + 1;
                    rd_acc_cnt++;
                end
                if (wr_req.en && edge_n >= wr_free_e) begin
                    ok = mdl_ok(wr_req.addr, wr_req.mask);
                    n  = nbytes(wr_req.mask);
                    wr_exp.done  = 1'b1;
                    wr_exp.valid = ok;
                    if (ok) begin
                        b = wr_req.addr - BASE;
                        for (int i = 0; i < int'(n); i++) mdl_mem[b + i] = wr_req.data[8*i +: 8];
                    end
                    wr_pend = 1; wr_done_e = edge_n + WL; wr_free_e = wr_done_e + 1;
                    wr_acc_cnt++;
                end
            end
            #1;
            er = (rd_pend && edge_n == rd_done_e) ? rd_exp : '0;
            ew = (wr_pend && edge_n == wr_done_e) ? wr_exp : '0;
            check_val("rd_done",  rd_rsp.done,  er.done);
            check_val("rd_valid", rd_rsp.valid, er.valid);
            check_val("rd_data",  rd_rsp.data,  er.data);
            check_val("rd_addr",  rd_rsp.addr,  er.addr);
            check_val("wr_done",  wr_rsp.done,  ew.done);
            check_val("wr_valid", wr_rsp.valid, ew.valid);
            if (rd_rsp.done === 1'b1) begin
                dut_rd_dones++;
                last_rd_edge = edge_n; last_rd_data = rd_rsp.data;
                last_rd_addr = rd_rsp.addr; last_rd_valid = rd_rsp.valid;
                $display("rd edge=%0d addr=%08h data=%08h valid=%0b", edge_n, rd_rsp.addr, rd_rsp.data, rd_rsp.valid);
            end
            if (wr_rsp.done === 1'b1) begin
                dut_wr_dones++;
                last_wr_edge = edge_n; last_wr_valid = wr_rsp.valid;
                $display("wr edge=%0d valid=%0b", edge_n, wr_rsp.valid);
            end
            if (rd_pend && edge_n == rd_done_e) rd_pend = 0;
            if (wr_pend && edge_n == wr_done_e) wr_pend = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_acc(input bit is_rd);
        int unsigned c;
        bit got;
        c   = is_rd ? rd_acc_cnt : wr_acc_cnt;
        got = 0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            got = ((is_rd ? rd_acc_cnt : wr_acc_cnt) != c);
        end
        check_val(is_rd ? "rd_accept" : "wr_accept", 64'(got), 64'd1);
    endtask

    task automatic rd_op(input logic [31:0] a, input logic [3:0] m);
        int unsigned d0;
        d0 = dut_rd_dones;
        @(negedge clk);
        rd_req = '{addr: a, mask: m, en: 1'b1};
        wait_acc(1'b1);
        rd_req.en = 1'b0;
        repeat (RL + 1) @(negedge clk);
        check_val("rd_seen", 64'(dut_rd_dones - d0), 64'd1);
    endtask

    task automatic wr_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        int unsigned d0;
        d0 = dut_wr_dones;
        @(negedge clk);
        wr_req = '{addr: a, data: d, mask: m, en: 1'b1};
        wait_acc(1'b0);
        wr_req.en = 1'b0;
        repeat (WL + 1) @(negedge clk);
        check_val("wr_seen", 64'(dut_wr_dones - d0), 64'd1);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'h0000_1000 + 32'($urandom_range(0, 255));
            1:       return 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
            default: return 32'($urandom_range(0, 63));
        endcase
    endfunction

    function automatic logic [3:0] rand_mask();
        case ($urandom_range(0, 7))
            0, 1:    return 4'b0001;
            2, 3:    return 4'b0011;
            4, 5:    return 4'b1111;
            6:       return 4'b0101;
            default: return 4'($urandom);
        endcase
    endfunction

    logic [31:0] init_vals [16];

    initial begin
        int unsigned a0, w0, d0;
        // Reset held for two edges with requests pending on both channels.
        rst    = 1'b1;
        rd_req = '{addr: 32'hFFFF_FFF0, mask: 4'hF, en: 1'b1};
        wr_req = '{addr: 32'h0000_003C, data: 32'h0BAD_F00D, mask: 4'hF, en: 1'b1};
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd_req.en = 1'b0;
        wr_req.en = 1'b0;
        repeat (RL + 2) @(negedge clk);
        // Reset occupied edges 1-2; accepts happen on edge 3.
        check_val("rst_first_rd_edge", 64'(last_rd_edge), 64'(3 + RL));
        check_val("rst_first_wr_edge", 64'(last_wr_edge), 64'(3 + WL));
        check_val("rst_first_rd_valid", 64'(last_rd_valid), 64'd0);

        // Fill the 16-word test window.
        for (int i = 0; i < 16; i++) begin
            init_vals[i] = $urandom;
            wr_op(32'(i * 4), init_vals[i], 4'hF);
        end

        // Word write then read.
        wr_op(32'h10, 32'hDEAD_BEEF, 4'hF);
        check_val("word_wr_valid", 64'(last_wr_valid), 64'd1);
        rd_op(32'h10, 4'hF);
        check_val("word_rd_data",  64'(last_rd_data),  64'hDEAD_BEEF);
        check_val("word_rd_valid", 64'(last_rd_valid), 64'd1);
        check_val("word_rd_addr",  64'(last_rd_addr),  64'h10);

        // Byte and half lanes.
        wr_op(32'h12, 32'h0000_00A5, 4'b0001);
        wr_op(32'h10, 32'h0000_1234, 4'b0011);
        rd_op(32'h10, 4'hF);
        check_val("lane_word", 64'(last_rd_data), 64'hDEA5_1234);
        rd_op(32'h13, 4'b0001);
        check_val("lane_byte", 64'(last_rd_data), 64'h0000_00DE);

        // Illegal accesses.
        rd_op(32'h11, 4'b0011);
        check_val("ill_half_valid", 64'(last_rd_valid), 64'd0);
        check_val("ill_half_data",  64'(last_rd_data),  64'd0);
        wr_op(32'h12, 32'hCAFE_F00D, 4'hF);
        check_val("ill_wmis_valid", 64'(last_wr_valid), 64'd0);
        rd_op(32'h10, 4'hF);
        check_val("ill_wmis_keep", 64'(last_rd_data), 64'hDEA5_1234);
        wr_op(BASE + DEPTH * 4, 32'h5555_5555, 4'hF);
        check_val("ill_range_valid", 64'(last_wr_valid), 64'd0);
        rd_op(32'h0, 4'hF);
        check_val("ill_range_keep", 64'(last_rd_data), 64'(init_vals[0]));
        wr_op(32'h10, 32'hFFFF_FFFF, 4'b0101);
        check_val("ill_mask_wvalid", 64'(last_wr_valid), 64'd0);
        rd_op(32'h10, 4'b0101);
        check_val("ill_mask_rvalid", 64'(last_rd_valid), 64'd0);
        check_val("ill_mask_rdata",  64'(last_rd_data),  64'd0);
        rd_op(32'h10, 4'hF);
        check_val("ill_mask_keep", 64'(last_rd_data), 64'hDEA5_1234);

        // Same-edge write and read to one word.
        wr_op(32'h20, 32'h2222_2222, 4'hF);
        d0 = dut_rd_dones;
        @(negedge clk);
        wr_req = '{addr: 32'h20, data: 32'h1111_1111, mask: 4'hF, en: 1'b1};
        rd_req = '{addr: 32'h20, mask: 4'hF, en: 1'b1};
        wait_acc(1'b1);
        rd_req.en = 1'b0;
        wr_req.en = 1'b0;
        repeat (RL + 1) @(negedge clk);
        check_val("sim_seen", 64'(dut_rd_dones - d0), 64'd1);
        check_val("sim_old", 64'(last_rd_data), 64'h2222_2222);
        rd_op(32'h20, 4'hF);
        check_val("sim_new", 64'(last_rd_data), 64'h1111_1111);

        // Reset while a read is in BUSY.
        d0 = dut_rd_dones;
        @(negedge clk);
        rd_req = '{addr: 32'h8, mask: 4'hF, en: 1'b1};
        wait_acc(1'b1);
        rd_req.en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (RL + 2) @(negedge clk);
        check_val("abort_no_done", 64'(dut_rd_dones - d0), 64'd0);
        rd_op(32'h8, 4'hF);
        check_val("abort_next", 64'(last_rd_data), 64'(init_vals[2]));

        // en held high for 31 edges: accepts every L+1 cycles.
        a0 = dut_rd_dones;
        w0 = dut_wr_dones;
        @(negedge clk);
        rd_req = '{addr: 32'($urandom_range(0, 15) * 4), mask: 4'hF, en: 1'b1};
        wr_req = '{addr: 32'($urandom_range(0, 15) * 4), data: $urandom, mask: 4'hF, en: 1'b1};
        repeat (30) begin
            @(negedge clk);
            rd_req.addr = 32'($urandom_range(0, 15) * 4);
            wr_req.addr = 32'($urandom_range(0, 15) * 4);
            wr_req.data = $urandom;
        end
        @(negedge clk);
        rd_req.en = 1'b0;
        wr_req.en = 1'b0;
        repeat (RL + 2) @(negedge clk);
        check_val("hold_rd_rate", 64'(dut_rd_dones - a0), 64'((31 + RL) / (RL + 1)));
        check_val("hold_wr_rate", 64'(dut_wr_dones - w0), 64'((31 + WL) / (WL + 1)));

        // Random traffic, including occasional resets.
        repeat (400) begin
            @(negedge clk);
            rst    = ($urandom_range(0, 99) == 0);
            rd_req = '{addr: rand_addr(), mask: rand_mask(), en: 1'($urandom_range(0, 1))};
            wr_req = '{addr: rand_addr(), data: $urandom, mask: rand_mask(), en: 1'($urandom_range(0, 1))};
        end
        @(negedge clk);
        rst       = 1'b0;
        rd_req.en = 1'b0;
        wr_req.en = 1'b0;
        repeat (RL + 3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
